// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode values, instruction word layout and legality check.
// Used by both the program-load encoder and the instruction decoder.
package isa_pkg;

  localparam logic [4:0] OP_MOVI = 5'b11000;
  localparam logic [4:0] OP_ADD  = 5'b10101;
  localparam logic [4:0] OP_SUB  = 5'b11011;
  localparam logic [4:0] OP_BR   = 5'b01100;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ST   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [4:0] OP_XOR  = 5'b11100;
  localparam logic [4:0] OP_AND  = 5'b10110;
  localparam logic [4:0] OP_OR   = 5'b10111;
  localparam logic [4:0] OP_SHL  = 5'b11010;
  localparam logic [4:0] OP_SHR  = 5'b10100;
  localparam logic [4:0] OP_MUL  = 5'b11001;
  localparam logic [4:0] OP_CMP  = 5'b11110;

  localparam int OPC_LSB      = 27;
  localparam int RD_TYPE_BIT  = 26;
  localparam int RS1_TYPE_BIT = 25;
  localparam int RS2_TYPE_BIT = 24;
  localparam int RD_LSB       = 20;
  localparam int RS1_LSB      = 16;
  localparam int RS2_LSB      = 12;
  localparam int IMM_LSB      = 0;

  // Member order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [4:0]  opcode;
    logic        rd_type;
    logic        rs1_type;
    logic        rs2_type;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [11:0] imm;
  } instr_t;

  function automatic logic is_legal_opcode(input logic [4:0] op);
    case (op)
      OP_MOVI, OP_ADD, OP_SUB, OP_BR, OP_LD, OP_ST, OP_HALT,
      OP_XOR, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_MUL, OP_CMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: operand fields into one instruction word plus an opcode-legal flag.
module instr_field_packer
  import isa_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic        rd_type,
  input  logic        rs1_type,
  input  logic        rs2_type,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [11:0] imm,
  output instr_t      instr,
  output logic        legal
);

  always_comb begin
    instr          = '0;
    instr.opcode   = opcode;
    instr.rd_type  = rd_type;
    instr.rs1_type = rs1_type;
    instr.rs2_type = rs2_type;
    instr.rd       = rd;
    instr.rs1      = rs1;
    instr.rs2      = rs2;
    instr.imm      = imm;
    legal          = is_legal_opcode(opcode);
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program-load block: accepts field bundles, encodes them and writes them to
// sequential instruction-memory addresses through a one-cycle register stage.
module instr_stream_encoder
  import isa_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        in_opcode,
  input  logic              in_rd_type,
  input  logic              in_rs1_type,
  input  logic              in_rs2_type,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                err_illegal_q, err_illegal_d;
  logic                err_overflow_q, err_overflow_d;
  // issued counts legal words accepted, including the one still in the register stage.
  logic [ADDR_W:0]     issued_q, issued_d;
  logic                full_end_q, full_end_d;

  instr_t              packed_instr;
  logic                packed_legal;
  logic                accept;
  logic [ADDR_W:0]     issued_inc;

  instr_field_packer u_packer (
    .opcode   (in_opcode),
    .rd_type  (in_rd_type),
    .rs1_type (in_rs1_type),
    .rs2_type (in_rs2_type),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .instr    (packed_instr),
    .legal    (packed_legal)
  );

  assign accept     = in_valid && in_ready_q;
  assign issued_inc = issued_q + ONE_C;

  always_comb begin
    state_d        = state_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    word_count_d   = word_count_q;
    issued_d       = issued_q;
    err_illegal_d  = err_illegal_q;
    err_overflow_d = err_overflow_q;
    full_end_d     = full_end_q;

    if (imem_we_q && word_count_q != DEPTH_C) word_count_d = word_count_q + ONE_C;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_LOAD;
          word_count_d   = '0;
          issued_d       = '0;
          err_illegal_d  = 1'b0;
          err_overflow_d = 1'b0;
          full_end_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (packed_legal) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = issued_q[ADDR_W-1:0];
            imem_wdata_d = packed_instr;
            issued_d     = issued_inc;
          end else begin
            err_illegal_d = 1'b1;
          end
          if (in_last || (packed_legal && issued_inc == DEPTH_C)) begin
            state_d    = S_FLUSH;
            full_end_d = !in_last;
          end
        end
      end
      S_FLUSH: begin
        state_d        = S_DONE;
        err_overflow_d = full_end_q;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_FLUSH);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      word_count_q   <= '0;
      issued_q       <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      full_end_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      word_count_q   <= word_count_d;
      issued_q       <= issued_d;
      err_illegal_q  <= err_illegal_d;
      err_overflow_q <= err_overflow_d;
      full_end_q     <= full_end_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign word_count   = word_count_q;
  assign err_illegal  = err_illegal_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Program-load block that packs instruction fields into 32-bit instruction words and writes them sequentially into instruction memory. It is the producer side of the instruction decoder. A host, test harness or UART bridge streams operand fields through a valid/ready handshake. The block checks each opcode against the legal ISA set, encodes the word, and writes it at an auto-incrementing address. It sits between the program source and the instruction-memory write port, ahead of the fetch/decode path.

## Interface
Parameters:
- DEPTH, 256, instruction-memory words; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), address width

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a new load at address 0
- in_valid  in  1  field bundle valid
- in_ready  out  1  block accepts bundle this cycle
- in_last  in  1  bundle is final instruction of the program
- in_opcode  in  5  opcode
- in_rd_type, in_rs1_type, in_rs2_type  in  1 each  1 = vector register, 0 = scalar
- in_rd, in_rs1, in_rs2  in  4 each  register indices
- in_imm  in  12  immediate / branch offset
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- busy  out  1  state is LOAD or FLUSH
- done  out  1  level; load finished, held until next start or rst
- word_count  out  ADDR_W+1  words written in current load
- err_illegal  out  1  sticky; at least one bundle had an illegal opcode
- err_overflow  out  1  sticky; memory filled before in_last

## Operation
- Word format: [31:27] opcode, [26] rd_type, [25] rs1_type, [24] rs2_type, [23:20] rd, [19:16] rs1, [15:12] rs2, [11:0] imm. All fields are copied unchanged. Unused fields are encoded as supplied.
- Legal opcodes: 11000, 10101, 11011, 01100, 10001, 10010, 11111, 11100, 10110, 10111, 11010, 10100, 11001, 11110. Every other opcode is illegal.
- States: IDLE, LOAD, FLUSH, DONE.
  - IDLE → LOAD on start. word_count, err_illegal and err_overflow are cleared and done is deasserted in the same cycle.
  - LOAD: in_ready = 1 while word_count < DEPTH.
  - Handshake: a bundle is accepted when in_valid && in_ready.
  - Legal accepted bundle: the encoded word is registered and written in the next cycle.
  - Illegal accepted bundle: the bundle is dropped. No write, word_count unchanged, err_illegal set.
  - LOAD → FLUSH on acceptance of in_last (legal or illegal), or on acceptance of the bundle that takes word_count to DEPTH.
  - FLUSH: in_ready = 0. The pending write completes, then the state goes to DONE.
  - Overflow: err_overflow is set on entry to DONE if the load ended by reaching DEPTH without in_last. If the bundle that fills the last slot also carries in_last, there is no overflow.
  - DONE: done = 1 and in_ready = 0. DONE → LOAD on start.
- start in LOAD or FLUSH is ignored.
- word_count saturates at DEPTH. imem_addr never wraps.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, word_count 0, err_illegal 0, err_overflow 0; state IDLE.
- Latency: a legal bundle accepted at edge N gives imem_we = 1 during cycle N+1, with imem_addr equal to the old word_count. word_count increments at edge N+1.
- Throughput: one word per cycle, with back-to-back acceptance while in_ready is high.
- in_ready is a registered function of state and word_count only. It never depends on in_valid combinationally.
- done rises in the cycle after the final write (or after the in_last drop).
- Reset mid-load: imem_we deasserts at the reset edge. The pending word is discarded and all outputs take their reset values.

## Structure
- Shared package isa_pkg holds:
  - the opcode localparams, shared with the decoder
  - the field bit-position constants
  - the instr_t packed struct
  - the function is_legal_opcode()
- Sub-module instr_field_packer: combinational, fields → instr_t/32-bit word plus a legal flag.
- The top-level holds the FSM, the output register stage and the counter.

## Test plan
- mov-imm bundle: opcode 11000, types 000, rd=3, rs1=0, rs2=0, imm=0x0AB, in_last=1 → one write at address 0 with data 0xC03000AB; then done=1, word_count=1, no errors.
- Vector xor bundle: opcode 11100, types 111, rd=1, rs1=2, rs2=3, imm=0 → data 0xE7123000.
- Streaming: 5 legal bundles back-to-back with in_valid held high → writes at addresses 0–4 on consecutive cycles; word_count=5.
- Illegal opcode 00000 in position 2 of 4 → 3 writes at addresses 0, 1, 2; err_illegal=1; done=1.
- DEPTH=4, 6 bundles offered without in_last → 4 writes, then in_ready drops, err_overflow=1, done=1. Repeat with in_last on bundle 4 → err_overflow=0.
- rst asserted the cycle after an acceptance → no write, all outputs zero. A following start plus one bundle writes to address 0.
